first_nios1_system_cpu_ocimem_arbiter: RTL and testbench
========================================================

Name: first_nios1_system_cpu_ocimem_arbiter

Overview:
Sysclk-domain controller that shares the CPU's single-port on-chip debug memory (OCI RAM) between two requesters. One requester is the JTAG debug path, driven by the take_action_ocimem_a/b and take_no_action_ocimem_a strobes plus jdo. The other is the CPU's Avalon debug-slave port. It sequences JTAG read and write commands with address auto-increment, arbitrates against Avalon traffic, and returns JTAG read data on MonDReg.

Parameters:
ADDR_W, 8, OCI RAM word-address width (RAM depth 2^ADDR_W x 32).
JTAG_PRIORITY, 0, 0 = round-robin between JTAG and Avalon; 1 = a pending JTAG request always wins.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data from debug module
take_action_ocimem_a  in  1  load JTAG address; jdo[34] = 1 also queues a read
take_no_action_ocimem_a  in  1  queue JTAG read at current address
take_action_ocimem_b  in  1  queue JTAG write of jdo[34:3]
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read request
av_write  in  1  Avalon write request
av_writedata  in  32  Avalon write data
av_byteenable  in  4  Avalon byte enables
av_waitrequest  out  1  Avalon stall
av_readdata  out  32  Avalon read data
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  32  RAM write data
ram_be  out  4  RAM byte enables
ram_we  out  1  RAM write strobe
ram_re  out  1  RAM read strobe; data valid one cycle later
ram_rdata  in  32  RAM read data
MonDReg  out  32  last JTAG read data
mondreg_valid  out  1  one-cycle pulse when MonDReg updates
ocimem_overrun  out  1  sticky: a JTAG command was dropped

Behaviour:
- Reset values: MonDReg=0, mondreg_valid=0, ocimem_overrun=0, ram_we=0, ram_re=0, jaddr=0, FSM=IDLE, JTAG pending cleared. Assertion mid-operation aborts immediately; no RAM strobe is issued after reset.
- av_waitrequest = (av_read|av_write) & ~av_done. It is combinational and low when there is no request.
- JTAG request register is one deep: pend (rd/wr) plus 32-bit data.
  - take_action_ocimem_a: jaddr <= jdo[ADDR_W+16:17]. If jdo[34] = 1, queue a read.
  - take_no_action_ocimem_a: queue a read.
  - take_action_ocimem_b: queue a write of jdo[34:3] with be = 4'hF.
- Drop rules (each sets ocimem_overrun; the dropped command has no effect):
  - a queue strobe arriving while pend is set, or while a JTAG op is in flight;
  - a and b asserted in the same cycle: a is processed, b is dropped.
- ocimem_overrun clears on take_action_ocimem_a with jdo[35] = 1.
- FSM states: IDLE, JRD, JRD_WAIT, JWR, AVRD, AVRD_WAIT, AVWR.
  - IDLE: grant per JTAG_PRIORITY. Round-robin favours the requester not granted last; the last-grant flag resets to "Avalon".
  - JRD: ram_re=1, ram_addr=jaddr, then go to JRD_WAIT.
  - JRD_WAIT: MonDReg <= ram_rdata, mondreg_valid=1 next cycle, jaddr <= jaddr+1, clear pend, go to IDLE.
  - JWR: ram_we=1, ram_addr=jaddr, ram_be=4'hF, jaddr <= jaddr+1, clear pend, go to IDLE.
  - AVRD: ram_re=1, ram_addr=av_address, then go to AVRD_WAIT.
  - AVRD_WAIT: av_done=1, av_readdata=ram_rdata, go to IDLE.
  - AVWR: ram_we=1 with Avalon address, data and byteenable; av_done=1; go to IDLE.
- Latency from the IDLE grant cycle:
  - Avalon write completes (waitrequest low) 1 cycle later.
  - Avalon read completes 2 cycles later.
  - JTAG read: strobe at T, MonDReg valid at T+4 when uncontended.
- jaddr wraps from 2^ADDR_W-1 to 0.
- Avalon request fields are sampled while the master holds them stable under waitrequest; they are not latched.
- When the RAM is idle, ram_we and ram_re = 0 and ram_addr/ram_wdata are don't-care.

Test Plan:
- Reset, then take_action_ocimem_a with jdo[24:17]=8'h10 and jdo[34]=1, RAM[0x10]=32'hDEADBEEF -> MonDReg=DEADBEEF with mondreg_valid pulse at T+4; jaddr=0x11.
- Three take_action_ocimem_b writes (data 1, 2, 3) starting at address 0xFF, spaced 4 cycles apart -> RAM[0xFF]=1, RAM[0x00]=2, RAM[0x01]=3 (wrap); ocimem_overrun=0.
- Two take_no_action_ocimem_a strobes on consecutive cycles -> one read only; ocimem_overrun=1. Then take_action_ocimem_a with jdo[35]=1 -> ocimem_overrun=0.
- Avalon read held continuously plus JTAG reads re-queued each completion, JTAG_PRIORITY=0 -> grants strictly alternate, and neither requester waits more than one foreign op. With JTAG_PRIORITY=1, Avalon is granted only while pend=0.
- Avalon write addr 5, byteenable 4'b0011, data 32'hAABBCCDD -> ram_we one cycle, ram_be=0011; waitrequest high 1 cycle then low.
- reset_n asserted during JRD_WAIT -> MonDReg=0, no mondreg_valid pulse, FSM=IDLE, ram_re=0 immediately.

Source files
------------

// File: rtl/first_nios1_system_cpu_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug path and the Avalon debug slave.
// JTAG commands are queued one deep and use an auto-incrementing address. Read data lands in MonDReg.
module first_nios1_system_cpu_ocimem_arbiter #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned JTAG_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic              av_waitrequest,
    output logic [31:0]       av_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              mondreg_valid,
    output logic              ocimem_overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StJrd,
        StJrdWait,
        StJwr,
        StAvrd,
        StAvrdWait,
        StAvwr
    } state_e;

    state_e              state_q;
    logic                pend_rd_q;
    logic                pend_wr_q;
    logic [31:0]         pend_data_q;
    logic [ADDR_W-1:0]   jaddr_q;
    logic                last_jtag_q;

    logic                jtag_busy;
    logic                a_queues_rd;
    logic                rd_strobe;
    logic                rd_drop;
    logic                b_drop;
    logic                queue_rd;
    logic                queue_wr;
    logic                load_addr;
    logic                clr_overrun;
    logic                cmd_drop;
    logic                jtag_req;
    logic                av_req;
    logic                grant_jtag;
    logic                av_done;
    logic                unused_jdo;

    // Pend stays set until the op retires, so it also covers the in-flight window.
    assign jtag_busy   = pend_rd_q | pend_wr_q;
    assign a_queues_rd = take_action_ocimem_a & jdo[34];
    assign rd_strobe   = take_no_action_ocimem_a | a_queues_rd;
    assign rd_drop     = rd_strobe & jtag_busy;
    assign b_drop      = take_action_ocimem_b &
                         (jtag_busy | take_action_ocimem_a | take_no_action_ocimem_a);
    assign queue_rd    = rd_strobe & ~jtag_busy;
    assign queue_wr    = take_action_ocimem_b & ~b_drop;
    // A dropped address-plus-read command has no effect at all, including its address load.
    assign load_addr   = take_action_ocimem_a & ~(a_queues_rd & jtag_busy);
    assign clr_overrun = load_addr & jdo[35];
    assign cmd_drop    = rd_drop | b_drop;

    assign jtag_req    = jtag_busy;
    assign av_req      = av_read | av_write;
    assign grant_jtag  = jtag_req & (~av_req | (JTAG_PRIORITY != 0) | ~last_jtag_q);

    assign av_done        = (state_q == StAvrdWait) || (state_q == StAvwr);
    assign av_waitrequest = av_req & ~av_done;
    assign av_readdata    = (state_q == StAvrdWait) ? ram_rdata : 32'h0;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            pend_rd_q      <= 1'b0;
            pend_wr_q      <= 1'b0;
            pend_data_q    <= 32'h0;
            jaddr_q        <= '0;
            last_jtag_q    <= 1'b0;
            ram_addr       <= '0;
            ram_wdata      <= 32'h0;
            ram_be         <= 4'h0;
            ram_we         <= 1'b0;
            ram_re         <= 1'b0;
            MonDReg        <= 32'h0;
            mondreg_valid  <= 1'b0;
            ocimem_overrun <= 1'b0;
        end else begin
            mondreg_valid <= 1'b0;
            ram_we        <= 1'b0;
            ram_re        <= 1'b0;

            if (cmd_drop) begin
                ocimem_overrun <= 1'b1;
            end else if (clr_overrun) begin
                ocimem_overrun <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (grant_jtag) begin
                        last_jtag_q <= 1'b1;
                        ram_addr    <= jaddr_q;
                        if (pend_rd_q) begin
                            state_q <= StJrd;
                            ram_re  <= 1'b1;
                        end else begin
                            state_q   <= StJwr;
                            ram_we    <= 1'b1;
                            ram_wdata <= pend_data_q;
                            ram_be    <= 4'hF;
                        end
                    end else if (av_req) begin
                        last_jtag_q <= 1'b0;
                        ram_addr    <= av_address;
                        if (av_write) begin
                            state_q   <= StAvwr;
                            ram_we    <= 1'b1;
                            ram_wdata <= av_writedata;
                            ram_be    <= av_byteenable;
                        end else begin
                            state_q <= StAvrd;
                            ram_re  <= 1'b1;
                        end
                    end
                end
                StJrd: begin
                    state_q <= StJrdWait;
                end
                StJrdWait: begin
                    MonDReg       <= ram_rdata;
                    mondreg_valid <= 1'b1;
                    jaddr_q       <= jaddr_q + ADDR_W'(1);
                    pend_rd_q     <= 1'b0;
                    state_q       <= StIdle;
                end
                StJwr: begin
                    jaddr_q   <= jaddr_q + ADDR_W'(1);
                    pend_wr_q <= 1'b0;
                    state_q   <= StIdle;
                end
                StAvrd: begin
                    state_q <= StAvrdWait;
                end
                StAvrdWait, StAvwr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (queue_rd) begin
                pend_rd_q <= 1'b1;
            end
            if (queue_wr) begin
                pend_wr_q   <= 1'b1;
                pend_data_q <= jdo[34:3];
            end
            // An explicit address load overrides the post-op increment.
            if (load_addr) begin
                jaddr_q <= jdo[ADDR_W+16:17];
            end
        end
    end

endmodule

// File: tb/tb_first_nios1_system_cpu_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter: one round-robin instance and one JTAG-priority instance,
// each with its own behavioural RAM.
module tb_first_nios1_system_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta_a, tna_a, ta_b;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;

    logic        av_wait0, av_wait1;
    logic [31:0] av_rdata0, av_rdata1;
    logic [7:0]  ram_addr0, ram_addr1;
    logic [31:0] ram_wdata0, ram_wdata1;
    logic [3:0]  ram_be0, ram_be1;
    logic        ram_we0, ram_we1, ram_re0, ram_re1;
    logic [31:0] ram_rdata0, ram_rdata1;
    logic [31:0] mon0, mon1;
    logic        mval0, mval1, ovr0, ovr1;

    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    first_nios1_system_cpu_ocimem_arbiter #(.ADDR_W(8), .JTAG_PRIORITY(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a),
        .take_action_ocimem_b(ta_b),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_waitrequest(av_wait0), .av_readdata(av_rdata0),
        .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_be(ram_be0),
        .ram_we(ram_we0), .ram_re(ram_re0), .ram_rdata(ram_rdata0),
        .MonDReg(mon0), .mondreg_valid(mval0), .ocimem_overrun(ovr0)
    );

    first_nios1_system_cpu_ocimem_arbiter #(.ADDR_W(8), .JTAG_PRIORITY(1)) u_dut_pri (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a),
        .take_action_ocimem_b(ta_b),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_waitrequest(av_wait1), .av_readdata(av_rdata1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_be(ram_be1),
        .ram_we(ram_we1), .ram_re(ram_re1), .ram_rdata(ram_rdata1),
        .MonDReg(mon1), .mondreg_valid(mval1), .ocimem_overrun(ovr1)
    );

    always @(posedge clk) begin
        if (pre_we) begin
            mem0[pre_addr] <= pre_data;
            mem1[pre_addr] <= pre_data;
        end
        for (int b = 0; b < 4; b++) begin
            if (ram_we0 && ram_be0[b]) mem0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
            if (ram_we1 && ram_be1[b]) mem1[ram_addr1][8*b +: 8] <= ram_wdata1[8*b +: 8];
        end
        if (ram_re0) ram_rdata0 <= mem0[ram_addr0];
        if (ram_re1) ram_rdata1 <= mem1[ram_addr1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        tick();
        pre_we   = 1'b0;
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd, input logic clr);
        logic [37:0] v;
        v         = '0;
        v[24:17]  = addr;
        v[34]     = rd;
        v[35]     = clr;
        return v;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] v;
        v       = '0;
        v[34:3] = data;
        return v;
    endfunction

    int   pulses;
    int   n_ops0, n_ops1;
    logic cur, prev0, prev1;
    logic have0, have1;

    initial begin
        reset_n = 1'b0;
        jdo = '0; ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
        av_address = '0; av_read = 1'b0; av_write = 1'b0;
        av_writedata = '0; av_byteenable = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        check("rst_mondreg", mon0, 32'h0);
        check("rst_valid", {31'b0, mval0}, 32'h0);
        check("rst_overrun", {31'b0, ovr0}, 32'h0);
        check("rst_ram_we", {31'b0, ram_we0}, 32'h0);
        check("rst_ram_re", {31'b0, ram_re0}, 32'h0);
        check("rst_waitreq", {31'b0, av_wait0}, 32'h0);

        preload(8'h10, 32'hDEADBEEF);
        preload(8'h11, 32'hCAFEF00D);
        preload(8'h05, 32'h11223344);
        preload(8'h20, 32'hA0A0A0A0);
        preload(8'h30, 32'h55555555);
        preload(8'h41, 32'h41414141);

        // JTAG read at 0x10: MonDReg valid exactly four cycles after the strobe
        jdo = mk_a(8'h10, 1'b1, 1'b0); ta_a = 1'b1;
        tick(); ta_a = 1'b0;
        tick();
        tick();
        check("jrd_valid_early", {31'b0, mval0}, 32'h0);
        tick();
        check("jrd_data", mon0, 32'hDEADBEEF);
        check("jrd_valid", {31'b0, mval0}, 32'h1);
        tick();
        check("jrd_valid_pulse", {31'b0, mval0}, 32'h0);

        // Follow-on read proves the address advanced to 0x11
        tna_a = 1'b1;
        tick(); tna_a = 1'b0;
        repeat (3) tick();
        check("jrd_incr_data", mon0, 32'hCAFEF00D);
        check("jrd_incr_valid", {31'b0, mval0}, 32'h1);
        repeat (2) tick();

        // Three writes starting at 0xFF wrap to 0x00 and 0x01
        jdo = mk_a(8'hFF, 1'b0, 1'b0); ta_a = 1'b1;
        tick(); ta_a = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            jdo = mk_b(32'(i)); ta_b = 1'b1;
            tick(); ta_b = 1'b0;
            repeat (3) tick();
        end
        tick();
        check("jwr_ff", mem0[8'hFF], 32'h1);
        check("jwr_00", mem0[8'h00], 32'h2);
        check("jwr_01", mem0[8'h01], 32'h3);
        check("jwr_overrun", {31'b0, ovr0}, 32'h0);

        // Back-to-back read strobes: second is dropped
        tna_a = 1'b1;
        tick(); tick();
        tna_a = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mval0) pulses++;
        end
        check("dup_rd_pulses", 32'(pulses), 32'h1);
        check("dup_rd_overrun", {31'b0, ovr0}, 32'h1);
        jdo = mk_a(8'h00, 1'b0, 1'b1); ta_a = 1'b1;
        tick(); ta_a = 1'b0;
        check("overrun_clear", {31'b0, ovr0}, 32'h0);

        // a and b together: a loads 0x30, b is dropped and writes nothing
        jdo = mk_a(8'h30, 1'b0, 1'b0); ta_a = 1'b1; ta_b = 1'b1;
        tick(); ta_a = 1'b0; ta_b = 1'b0;
        repeat (4) tick();
        check("ab_overrun", {31'b0, ovr0}, 32'h1);
        check("ab_no_write", mem0[8'h30], 32'h55555555);
        jdo = mk_a(8'h30, 1'b0, 1'b1); ta_a = 1'b1;
        tick(); ta_a = 1'b0;
        check("ab_overrun_clear", {31'b0, ovr0}, 32'h0);

        // Avalon write, partial byte enables
        av_address = 8'h05; av_byteenable = 4'b0011; av_writedata = 32'hAABBCCDD;
        av_write = 1'b1;
        #1;
        check("avwr_wait_hi", {31'b0, av_wait0}, 32'h1);
        tick();
        check("avwr_wait_lo", {31'b0, av_wait0}, 32'h0);
        check("avwr_we", {31'b0, ram_we0}, 32'h1);
        check("avwr_be", {28'b0, ram_be0}, 32'h3);
        check("avwr_addr", {24'b0, ram_addr0}, 32'h5);
        tick(); av_write = 1'b0;
        check("avwr_we_once", {31'b0, ram_we0}, 32'h0);
        tick();
        check("avwr_mem", mem0[8'h05], 32'h1122CCDD);

        // Avalon read completes two cycles after the grant
        av_address = 8'h20; av_read = 1'b1;
        #1;
        check("avrd_wait0", {31'b0, av_wait0}, 32'h1);
        tick();
        check("avrd_wait1", {31'b0, av_wait0}, 32'h1);
        tick();
        check("avrd_wait2", {31'b0, av_wait0}, 32'h0);
        check("avrd_data", av_rdata0, 32'hA0A0A0A0);
        av_read = 1'b0;
        tick();

        // Continuous Avalon reads against continuously re-queued JTAG reads
        jdo = mk_a(8'h80, 1'b0, 1'b0); ta_a = 1'b1;
        tick(); ta_a = 1'b0;
        av_address = 8'h20; av_read = 1'b1; tna_a = 1'b1;
        have0 = 1'b0; have1 = 1'b0; prev0 = 1'b0; prev1 = 1'b0;
        n_ops0 = 0; n_ops1 = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ram_re0) begin
                cur = (ram_addr0 == 8'h20);
                if (have0) check("rr_alternate", {31'b0, cur}, {31'b0, ~prev0});
                prev0 = cur; have0 = 1'b1; n_ops0++;
            end
            if (ram_re1) begin
                cur = (ram_addr1 == 8'h20);
                if (have1) check("pri_alternate", {31'b0, cur}, {31'b0, ~prev1});
                prev1 = cur; have1 = 1'b1; n_ops1++;
            end
        end
        check("rr_op_count", {31'b0, n_ops0 >= 12}, 32'h1);
        check("pri_op_count", {31'b0, n_ops1 >= 12}, 32'h1);
        av_read = 1'b0; tna_a = 1'b0;
        repeat (8) tick();

        // After a JTAG grant, a simultaneous pair splits the two policies
        jdo = mk_a(8'h40, 1'b1, 1'b1); ta_a = 1'b1;
        tick(); ta_a = 1'b0;
        repeat (6) tick();
        jdo = mk_a(8'h41, 1'b1, 1'b0); ta_a = 1'b1;
        tick(); ta_a = 1'b0;
        av_address = 8'h20; av_read = 1'b1;
        tick();
        check("rr_grant_re", {31'b0, ram_re0}, 32'h1);
        check("rr_grant_av", {24'b0, ram_addr0}, 32'h20);
        check("pri_grant_re", {31'b0, ram_re1}, 32'h1);
        check("pri_grant_jtag", {24'b0, ram_addr1}, 32'h41);
        av_read = 1'b0;
        repeat (8) tick();
        check("pri_jtag_data", mon1, 32'h41414141);

        // Reset while in JRD_WAIT aborts the read
        jdo = mk_a(8'h10, 1'b1, 1'b0); ta_a = 1'b1;
        tick(); ta_a = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("abort_mondreg", mon0, 32'h0);
        check("abort_ram_re", {31'b0, ram_re0}, 32'h0);
        check("abort_valid", {31'b0, mval0}, 32'h0);
        tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mval0 || ram_re0 || ram_we0) pulses++;
        end
        check("abort_quiet", 32'(pulses), 32'h0);
        check("abort_mondreg_hold", mon0, 32'h0);
        // Idle FSM with nothing pending serves an Avalon read in two cycles
        av_address = 8'h20; av_read = 1'b1;
        tick();
        tick();
        check("abort_idle_avrd", {31'b0, av_wait0}, 32'h0);
        check("abort_idle_data", av_rdata0, 32'hA0A0A0A0);
        av_read = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
